colour_scan_ctrl: RTL and testbench
===================================

// Module: colour_scan_ctrl
// PURPOSE
// Sequences the colour_detect datapath across RED, GREEN and BLUE on successive camera frames.
// Drives its colour select and threshold, and latches each frame's pixel count at start of frame.
// After a full R/G/B scan, reports the dominant colour to the motor/FFT integration logic.
// Sits between the camera frame-timing logic and colour_detect.
// PARAMETERS
// MIN_PIXELS      2000      min count for a colour to be reported dominant (17-bit compare)
// THRESH_DEFAULT  4'd8      upper_thresh value driven out of reset
// TIMEOUT_CYCLES  4194304   max clk cycles between sop pulses while ARM/SCAN before abort
// PORTS
// clk            in   1   system clock
// resetn         in   1   synchronous active-low reset
// start          in   1   pulse: begin scan (ignored unless IDLE)
// stop           in   1   pulse: abort to IDLE (highest priority)
// continuous     in   1   1: rescan indefinitely; 0: one scan then IDLE (sampled at scan end)
// thresh_in      in   4   threshold to apply; latched on accepted start
// sop            in   1   start-of-frame pulse, shared with colour_detect
// colour_pixels  in   17  colour_detect pixel count (value of the frame just ended is valid in the sop cycle)
// colour_sel     out  2   to colour_detect: 0=RED 1=GREEN 2=BLUE
// upper_thresh   out  4   to colour_detect threshold
// busy           out  1   high in ARM or SCAN
// result_valid   out  1   1-cycle pulse: counts/dominant updated
// dominant       out  2   0/1/2 colour index, 3=NONE
// red_count      out  17  latched RED frame count
// green_count    out  17  latched GREEN frame count
// blue_count     out  17  latched BLUE frame count
// timeout_err    out  1   sticky: sop timeout occurred; cleared by accepted start
// BEHAVIOUR
// - Reset values (resetn=0 at posedge):
//   - state=IDLE; colour_sel=0; upper_thresh=THRESH_DEFAULT; busy=0; result_valid=0.
//   - dominant=3; all counts=0; timeout_err=0; idx=0; timeout counter=0.
// - All outputs are registered. FSM states: IDLE, ARM, SCAN; idx (0..2) tracks the colour in SCAN.
// - IDLE:
//   - start -> ARM; upper_thresh<=thresh_in; colour_sel<=0; timeout_err<=0.
//   - An sop in the same cycle as start is not consumed.
// - ARM (discards the partial frame in flight):
//   - sop -> SCAN, idx=0, colour_sel stays 0.
// - SCAN, on each sop:
//   - Latch colour_pixels into the count register selected by idx.
//   - If idx<2: idx+1, colour_sel<=idx+1.
//   - If idx==2: colour_sel<=0, idx<=0; next state SCAN if continuous, else IDLE.
// - Compare stage, cycle after the idx==2 latch:
//   - Winner = largest count; ties resolved RED>GREEN>BLUE (later colour must be strictly greater).
//   - dominant<=winner if its count>=MIN_PIXELS, else 3.
//   - result_valid=1 for exactly that cycle.
// - Latency: dominant/result_valid appear 1 cycle after the blue-frame sop; colour_sel changes 1 cycle after sop.
// - Timeout counter:
//   - Clears on entry to ARM and on every sop while busy; increments otherwise while busy.
//   - At TIMEOUT_CYCLES-1: -> IDLE, timeout_err<=1, colour_sel<=0, no result_valid.
// - stop: any state -> IDLE next cycle; colour_sel<=0; counts and dominant retain old values; no result_valid.
// - Priority: resetn > stop > timeout > sop > start.
// - Partial scans never update dominant. Counts are stored at 17-bit width, no saturation.
// - upper_thresh is held constant from start until the next accepted start; thresh_in changes mid-scan are ignored.
// - resetn mid-scan: all reset values next cycle; any pending result is discarded.
// TESTING
// - Reset, then idle 10 cycles -> colour_sel=0, upper_thresh=8, dominant=3, busy=0, result_valid never asserts.
// - start(thresh 5), then 4 sops with counts x, 3000, 100, 200 ->
//   - colour_sel sequence 0, 1, 2, 0; red/green/blue_count = 3000/100/200.
//   - dominant=0 with a 1-cycle result_valid; IDLE (continuous=0).
// - Counts 1500/1500/1999 with MIN_PIXELS=2000 -> dominant=3. Counts 2500/2500/2400 -> dominant=0 (tie goes to RED).
// - continuous=1 for 7 sops -> two result_valid pulses, 3 frames apart; busy stays high.
// - stop asserted in the same cycle as the blue sop -> IDLE, counts unchanged, no result_valid.
// - No sop for TIMEOUT_CYCLES cycles in SCAN -> IDLE, timeout_err=1; the next start clears it.

Source files
------------

// File: rtl/colour_scan_ctrl.sv
// Steps colour_detect through RED, GREEN and BLUE on successive frames, latches each
// frame's pixel count at start of frame and reports the dominant colour after a full scan.
module colour_scan_ctrl #(
   parameter int         MIN_PIXELS     = 2000,
   parameter logic [3:0] THRESH_DEFAULT = 4'd8,
   parameter int         TIMEOUT_CYCLES = 4194304
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        stop,
   input  logic        continuous,
   input  logic [3:0]  thresh_in,
   input  logic        sop,
   input  logic [16:0] colour_pixels,
   output logic [1:0]  colour_sel,
   output logic [3:0]  upper_thresh,
   output logic        busy,
   output logic        result_valid,
   output logic [1:0]  dominant,
   output logic [16:0] red_count,
   output logic [16:0] green_count,
   output logic [16:0] blue_count,
   output logic        timeout_err
);

   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]     MIN_CNT  = 17'(MIN_PIXELS);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SCAN} state_t;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        colour_sel_q, colour_sel_d;
   logic [3:0]        upper_thresh_q, upper_thresh_d;
   logic              busy_q, busy_d;
   logic              result_valid_q, result_valid_d;
   logic [1:0]        dominant_q, dominant_d;
   logic [16:0]       red_count_q, red_count_d;
   logic [16:0]       green_count_q, green_count_d;
   logic [16:0]       blue_count_q, blue_count_d;
   logic              timeout_err_q, timeout_err_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

   // A later colour only wins when strictly greater, so ties favour RED, then GREEN.
   function automatic logic [1:0] pick_dominant(input logic [16:0] r,
                                                input logic [16:0] g,
                                                input logic [16:0] b);
      logic [1:0]  win;
      logic [16:0] best;
      win  = 2'd0;
      best = r;
      if (g > best) begin
         win  = 2'd1;
         best = g;
      end
      if (b > best) begin
         win  = 2'd2;
         best = b;
      end
      return (best >= MIN_CNT) ? win : 2'd3;
   endfunction

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      colour_sel_d   = colour_sel_q;
      upper_thresh_d = upper_thresh_q;
      result_valid_d = 1'b0;
      dominant_d     = dominant_q;
      red_count_d    = red_count_q;
      green_count_d  = green_count_q;
      blue_count_d   = blue_count_q;
      timeout_err_d  = timeout_err_q;
      tmo_cnt_d      = tmo_cnt_q;

      if (stop) begin
         state_d      = ST_IDLE;
         idx_d        = 2'd0;
         colour_sel_d = 2'd0;
         tmo_cnt_d    = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d        = ST_ARM;
                  upper_thresh_d = thresh_in;
                  colour_sel_d   = 2'd0;
                  timeout_err_d  = 1'b0;
                  idx_d          = 2'd0;
                  tmo_cnt_d      = '0;
               end
            end
            ST_ARM, ST_SCAN: begin
               if (tmo_cnt_q == TMO_LAST) begin
                  state_d       = ST_IDLE;
                  timeout_err_d = 1'b1;
                  colour_sel_d  = 2'd0;
                  idx_d         = 2'd0;
                  tmo_cnt_d     = '0;
               end else if (sop) begin
                  tmo_cnt_d = '0;
                  if (state_q == ST_ARM) begin
                     // The frame in flight when armed is partial, so its count is dropped.
                     state_d      = ST_SCAN;
                     idx_d        = 2'd0;
                     colour_sel_d = 2'd0;
                  end else begin
                     case (idx_q)
                        2'd0:    red_count_d   = colour_pixels;
                        2'd1:    green_count_d = colour_pixels;
                        default: blue_count_d  = colour_pixels;
                     endcase
                     if (idx_q != 2'd2) begin
                        idx_d        = idx_q + 2'd1;
                        colour_sel_d = idx_q + 2'd1;
                     end else begin
                        idx_d          = 2'd0;
                        colour_sel_d   = 2'd0;
                        dominant_d     = pick_dominant(red_count_q, green_count_q, colour_pixels);
                        result_valid_d = 1'b1;
                        state_d        = continuous ? ST_SCAN : ST_IDLE;
                     end
                  end
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         idx_q          <= 2'd0;
         colour_sel_q   <= 2'd0;
         upper_thresh_q <= THRESH_DEFAULT;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         dominant_q     <= 2'd3;
         red_count_q    <= '0;
         green_count_q  <= '0;
         blue_count_q   <= '0;
         timeout_err_q  <= 1'b0;
         tmo_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         colour_sel_q   <= colour_sel_d;
         upper_thresh_q <= upper_thresh_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
         dominant_q     <= dominant_d;
         red_count_q    <= red_count_d;
         green_count_q  <= green_count_d;
         blue_count_q   <= blue_count_d;
         timeout_err_q  <= timeout_err_d;
         tmo_cnt_q      <= tmo_cnt_d;
      end
   end

   assign colour_sel   = colour_sel_q;
   assign upper_thresh = upper_thresh_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign dominant     = dominant_q;
   assign red_count    = red_count_q;
   assign green_count  = green_count_q;
   assign blue_count   = blue_count_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_colour_scan_ctrl.sv
// Scoreboard bench for colour_scan_ctrl: expected scan results are queued as the blue
// frame is driven and compared when result_valid fires.
module tb_colour_scan_ctrl;

   localparam int TMO     = 64;
   localparam int SOP_GAP = 4;

   logic        clk = 1'b0;
   logic        resetn, start, stop, continuous, sop;
   logic [3:0]  thresh_in;
   logic [16:0] colour_pixels;
   logic [1:0]  colour_sel;
   logic [3:0]  upper_thresh;
   logic        busy, result_valid, timeout_err;
   logic [1:0]  dominant;
   logic [16:0] red_count, green_count, blue_count;

   typedef struct {
      logic [1:0]  dom;
      logic [16:0] r;
      logic [16:0] g;
      logic [16:0] b;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_rv_cyc = -1;
   int   prev_rv_cyc = -1;

   colour_scan_ctrl #(
      .MIN_PIXELS    (2000),
      .THRESH_DEFAULT(4'd8),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .stop         (stop),
      .continuous   (continuous),
      .thresh_in    (thresh_in),
      .sop          (sop),
      .colour_pixels(colour_pixels),
      .colour_sel   (colour_sel),
      .upper_thresh (upper_thresh),
      .busy         (busy),
      .result_valid (result_valid),
      .dominant     (dominant),
      .red_count    (red_count),
      .green_count  (green_count),
      .blue_count   (blue_count),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Result monitor: every result_valid must match the oldest queued expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1 && result_valid === 1'b1) begin
         prev_rv_cyc = last_rv_cyc;
         last_rv_cyc = cyc;
         if (sb_q.size() == 0) begin
            check_val("unexpected_result_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check_val("dominant", {30'd0, dominant}, {30'd0, mon_e.dom});
            check_val("red_count", {15'd0, red_count}, {15'd0, mon_e.r});
            check_val("green_count", {15'd0, green_count}, {15'd0, mon_e.g});
            check_val("blue_count", {15'd0, blue_count}, {15'd0, mon_e.b});
         end
      end
   end

   task automatic do_start(input logic [3:0] th);
      start     = 1'b1;
      thresh_in = th;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sop_pulse(input logic [16:0] val, input logic [1:0] exp_sel);
      sop           = 1'b1;
      colour_pixels = val;
      @(negedge clk);
      sop = 1'b0;
      check_val("colour_sel", {30'd0, colour_sel}, {30'd0, exp_sel});
      repeat (SOP_GAP - 1) @(negedge clk);
   endtask

   task automatic run_scan(input logic [16:0] r, input logic [16:0] g,
                           input logic [16:0] b, input logic [1:0] dom);
      exp_t e;
      e.dom = dom;
      e.r   = r;
      e.g   = g;
      e.b   = b;
      sop_pulse(r, 2'd1);
      sop_pulse(g, 2'd2);
      sb_q.push_back(e);
      sop_pulse(b, 2'd0);
   endtask

   task automatic one_shot(input logic [16:0] r, input logic [16:0] g,
                           input logic [16:0] b, input logic [1:0] dom);
      do_start(4'd5);
      sop_pulse(17'd1234, 2'd0);
      run_scan(r, g, b, dom);
      check_val("busy_after_single", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      resetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      sop = 1'b0; thresh_in = 4'd0; colour_pixels = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      check_val("rst_colour_sel", {30'd0, colour_sel}, 32'd0);
      check_val("rst_upper_thresh", {28'd0, upper_thresh}, 32'd8);
      check_val("rst_dominant", {30'd0, dominant}, 32'd3);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      check_val("rst_red", {15'd0, red_count}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("idle_result_valid", {31'd0, result_valid}, 32'd0);
      end

      // Basic single scan; threshold changes mid-scan must not reach the output.
      do_start(4'd5);
      check_val("armed_busy", {31'd0, busy}, 32'd1);
      check_val("armed_thresh", {28'd0, upper_thresh}, 32'd5);
      sop_pulse(17'd999, 2'd0);
      thresh_in = 4'd12;
      run_scan(17'd3000, 17'd100, 17'd200, 2'd0);
      check_val("scan_done_busy", {31'd0, busy}, 32'd0);
      check_val("held_thresh", {28'd0, upper_thresh}, 32'd5);

      // start coinciding with sop: that sop must not be taken as the ARM frame.
      start = 1'b1; sop = 1'b1; colour_pixels = 17'd777; thresh_in = 4'd9;
      @(negedge clk);
      start = 1'b0; sop = 1'b0;
      check_val("start_sop_sel", {30'd0, colour_sel}, 32'd0);
      check_val("start_sop_busy", {31'd0, busy}, 32'd1);
      repeat (SOP_GAP - 1) @(negedge clk);
      sop_pulse(17'd888, 2'd0);
      run_scan(17'd1500, 17'd1500, 17'd1999, 2'd3);
      check_val("thresh_9", {28'd0, upper_thresh}, 32'd9);

      one_shot(17'd2500, 17'd2500, 17'd2400, 2'd0);
      one_shot(17'd100, 17'd2600, 17'd2600, 2'd1);
      one_shot(17'd2100, 17'd2200, 17'd2300, 2'd2);
      one_shot(17'd131071, 17'd5, 17'd131070, 2'd0);
      one_shot(17'd2000, 17'd0, 17'd0, 2'd0);
      one_shot(17'd1999, 17'd0, 17'd0, 2'd3);

      // Continuous mode over 7 sops: two results, three frames apart.
      continuous = 1'b1;
      do_start(4'd3);
      sop_pulse(17'd1, 2'd0);
      run_scan(17'd10, 17'd3000, 17'd20, 2'd1);
      run_scan(17'd4000, 17'd50, 17'd60, 2'd0);
      check_val("cont_busy", {31'd0, busy}, 32'd1);
      check_val("cont_spacing", prev_rv_cyc + 3 * SOP_GAP, last_rv_cyc);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      continuous = 1'b0;
      check_val("stop_busy", {31'd0, busy}, 32'd0);

      // stop together with the blue sop: no result, blue/dominant keep old values.
      do_start(4'd4);
      sop_pulse(17'd1, 2'd0);
      sop_pulse(17'd10, 2'd1);
      sop_pulse(17'd20, 2'd2);
      stop = 1'b1; sop = 1'b1; colour_pixels = 17'd30;
      @(negedge clk);
      stop = 1'b0; sop = 1'b0;
      check_val("stopblue_busy", {31'd0, busy}, 32'd0);
      check_val("stopblue_sel", {30'd0, colour_sel}, 32'd0);
      check_val("stopblue_rv", {31'd0, result_valid}, 32'd0);
      check_val("stopblue_red", {15'd0, red_count}, 32'd10);
      check_val("stopblue_green", {15'd0, green_count}, 32'd20);
      check_val("stopblue_blue", {15'd0, blue_count}, 32'd60);
      check_val("stopblue_dom", {30'd0, dominant}, 32'd0);
      repeat (3) @(negedge clk);

      // sop timeout while scanning.
      do_start(4'd6);
      sop = 1'b1; colour_pixels = 17'd5;
      @(negedge clk);
      sop = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check_val("timeout_cycles", n, TMO);
      check_val("timeout_err_set", {31'd0, timeout_err}, 32'd1);
      check_val("timeout_sel", {30'd0, colour_sel}, 32'd0);
      check_val("timeout_dom", {30'd0, dominant}, 32'd0);
      do_start(4'd7);
      check_val("timeout_err_clr", {31'd0, timeout_err}, 32'd0);
      check_val("restart_busy", {31'd0, busy}, 32'd1);

      // Reset in the middle of a scan.
      sop_pulse(17'd1, 2'd0);
      sop_pulse(17'd55, 2'd1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check_val("midrst_red", {15'd0, red_count}, 32'd0);
      check_val("midrst_thresh", {28'd0, upper_thresh}, 32'd8);
      check_val("midrst_dom", {30'd0, dominant}, 32'd3);
      check_val("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);

      check_val("scoreboard_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
